// File: rtl/stream_buffer_prefetch_ctrl.sv
// Stream buffer sequencer: answers cache miss lookups from the buffered line,
// waits on a matching in-flight prefetch, and keeps a sequential in-page prefetch going.
module stream_buffer_prefetch_ctrl #(
    parameter int unsigned LINE_WIDTH = 256,
    parameter int unsigned PAGE_BITS  = 12,
    parameter int unsigned CNT_WIDTH  = 32,
    localparam int unsigned LINE_OFF    = $clog2(LINE_WIDTH / 8),
    localparam int unsigned LABEL_WIDTH = 32 - LINE_OFF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   flush_i,
    input  logic                   lookup_vld,
    input  logic [LABEL_WIDTH-1:0] lookup_label,
    output logic                   lookup_rdy,
    output logic                   resp_vld,
    output logic                   resp_hit,
    output logic [LINE_WIDTH-1:0]  resp_data,
    output logic [LABEL_WIDTH-1:0] sb_label_i,
    output logic                   sb_label_i_rdy,
    output logic                   sb_inv,
    input  logic [LABEL_WIDTH-1:0] sb_label_o,
    input  logic [LINE_WIDTH-1:0]  sb_data,
    input  logic                   sb_data_vld,
    input  logic                   sb_ready,
    output logic [CNT_WIDTH-1:0]   hit_cnt,
    output logic [CNT_WIDTH-1:0]   miss_cnt
);

    localparam int unsigned PG_IDX = PAGE_BITS - LINE_OFF;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FLUSH, S_ISSUE} state_t;

    state_t                 state, state_d;
    logic [LABEL_WIDTH-1:0] req_label, req_label_d;
    logic [LABEL_WIDTH-1:0] sb_label_d;
    logic                   resp_vld_d, resp_hit_d;
    logic [LINE_WIDTH-1:0]  resp_data_d;
    logic                   lk_match, req_match, page_end;

    assign lk_match  = (sb_label_o == lookup_label);
    assign req_match = (sb_label_o == req_label);
    // label+1 landed on the first line of a new page: no prefetch across it
    assign page_end  = (sb_label_i[PG_IDX-1:0] == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            req_label  <= '0;
            sb_label_i <= '0;
            resp_vld   <= 1'b0;
            resp_hit   <= 1'b0;
            resp_data  <= '0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
        end else begin
            state      <= state_d;
            req_label  <= req_label_d;
            sb_label_i <= sb_label_d;
            resp_vld   <= resp_vld_d;
            resp_hit   <= resp_hit_d;
            resp_data  <= resp_data_d;
            if (resp_vld_d && resp_hit_d && (hit_cnt != '1))
                hit_cnt <= hit_cnt + CNT_WIDTH'(1);
            if (resp_vld_d && !resp_hit_d && (miss_cnt != '1))
                miss_cnt <= miss_cnt + CNT_WIDTH'(1);
        end
    end

    always_comb begin
        state_d        = state;
        req_label_d    = req_label;
        sb_label_d     = sb_label_i;
        resp_vld_d     = 1'b0;
        resp_hit_d     = 1'b0;
        resp_data_d    = resp_data;
        lookup_rdy     = 1'b0;
        sb_inv         = 1'b0;
        sb_label_i_rdy = 1'b0;

        if (flush_i) begin
            // flush overrides everything; an outstanding wait is answered as a miss
            sb_inv  = 1'b1;
            state_d = S_IDLE;
            if (state == S_WAIT)
                resp_vld_d = 1'b1;
        end else begin
            unique case (state)
                S_IDLE: begin
                    lookup_rdy = 1'b1;
                    if (lookup_vld) begin
                        req_label_d = lookup_label;
                        resp_vld_d  = 1'b1;
                        if (en) begin
                            sb_label_d = lookup_label + LABEL_WIDTH'(1);
                            if (sb_data_vld && lk_match) begin
                                resp_hit_d  = 1'b1;
                                resp_data_d = sb_data;
                                state_d     = S_ISSUE;
                            end else if (!sb_ready && lk_match) begin
                                resp_vld_d = 1'b0;
                                state_d    = S_WAIT;
                            end else begin
                                state_d = S_FLUSH;
                            end
                        end
                    end
                end
                S_WAIT: begin
                    if (sb_data_vld && req_match) begin
                        resp_vld_d  = 1'b1;
                        resp_hit_d  = 1'b1;
                        resp_data_d = sb_data;
                        state_d     = S_ISSUE;
                    end else if (sb_ready && !sb_data_vld) begin
                        resp_vld_d = 1'b1;
                        state_d    = S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    sb_inv  = 1'b1;
                    state_d = S_ISSUE;
                end
                S_ISSUE: begin
                    if (page_end) begin
                        state_d = S_IDLE;
                    end else if (sb_ready) begin
                        sb_label_i_rdy = 1'b1;
                        state_d        = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_buffer_prefetch_ctrl.sv
// Bench for stream_buffer_prefetch_ctrl: directed vector table, hand sequences for
// wait/flush/reset/saturation, then random traffic against a transaction-level model.
module tb_stream_buffer_prefetch_ctrl;

    localparam int unsigned LINE_W = 256;
    localparam int unsigned PAGE_B = 12;
    localparam int unsigned CW     = 4;
    localparam int unsigned LW     = 32 - $clog2(LINE_W / 8);
    localparam int unsigned PG     = PAGE_B - $clog2(LINE_W / 8);
    localparam int          CMAX   = (1 << CW) - 1;

    logic              clk, rst, en, flush_i, lookup_vld;
    logic [LW-1:0]     lookup_label, sb_label_i, sb_label_o;
    logic              lookup_rdy, resp_vld, resp_hit, sb_label_i_rdy, sb_inv;
    logic [LINE_W-1:0] resp_data, sb_data;
    logic              sb_data_vld, sb_ready;
    logic [CW-1:0]     hit_cnt, miss_cnt;

    stream_buffer_prefetch_ctrl #(.LINE_WIDTH(LINE_W), .PAGE_BITS(PAGE_B), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .en(en), .flush_i(flush_i),
        .lookup_vld(lookup_vld), .lookup_label(lookup_label), .lookup_rdy(lookup_rdy),
        .resp_vld(resp_vld), .resp_hit(resp_hit), .resp_data(resp_data),
        .sb_label_i(sb_label_i), .sb_label_i_rdy(sb_label_i_rdy), .sb_inv(sb_inv),
        .sb_label_o(sb_label_o), .sb_data(sb_data), .sb_data_vld(sb_data_vld),
        .sb_ready(sb_ready), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: obligations still owed by the controller rather than a state machine.
    bit              m_wait, m_owe_inv, m_owe_iss, m_rv, m_rh;
    logic [LW-1:0]   m_req, m_lbl;
    logic [LINE_W-1:0] m_rd;
    int              m_hits, m_misses;

    function automatic bit m_cross();
        return (int'(m_lbl) % (1 << PG)) == 0;
    endfunction

    task automatic model_update();
        bit nv, nh;
        nv = 0; nh = 0;
        if (rst) begin
            m_wait = 0; m_owe_inv = 0; m_owe_iss = 0; m_rv = 0; m_rh = 0;
            m_req = '0; m_lbl = '0; m_rd = '0; m_hits = 0; m_misses = 0;
            return;
        end
        if (flush_i) begin
            if (m_wait) nv = 1;
            m_wait = 0; m_owe_inv = 0; m_owe_iss = 0;
        end else if (m_wait) begin
            if (sb_data_vld && sb_label_o == m_req) begin
                nv = 1; nh = 1; m_rd = sb_data; m_wait = 0; m_owe_iss = 1;
            end else if (sb_ready && !sb_data_vld) begin
                nv = 1; m_wait = 0; m_owe_inv = 1; m_owe_iss = 1;
            end
        end else if (m_owe_inv) begin
            m_owe_inv = 0;
        end else if (m_owe_iss) begin
            if (m_cross() || sb_ready) m_owe_iss = 0;
        end else if (lookup_vld) begin
            if (!en) begin
                nv = 1;
            end else begin
                m_lbl = lookup_label + LW'(1);
                if (sb_label_o == lookup_label && sb_data_vld) begin
                    nv = 1; nh = 1; m_rd = sb_data; m_owe_iss = 1;
                end else if (sb_label_o == lookup_label && !sb_ready) begin
                    m_wait = 1; m_req = lookup_label;
                end else begin
                    nv = 1; m_owe_inv = 1; m_owe_iss = 1;
                end
            end
        end
        m_rv = nv; m_rh = nh;
        if (nv && nh && m_hits < CMAX) m_hits++;
        if (nv && !nh && m_misses < CMAX) m_misses++;
    endtask

    logic o_rdy, o_rv, o_rh, o_inv, o_iss;
    logic [LW-1:0] o_lbl;
    logic [LINE_W-1:0] o_rd;

    // One clock: sample and check outputs before the edge, advance model at the edge.
    task automatic step();
        bit idle, e_iss;
        #1;
        o_rdy = lookup_rdy; o_rv = resp_vld; o_rh = resp_hit; o_rd = resp_data;
        o_inv = sb_inv; o_iss = sb_label_i_rdy; o_lbl = sb_label_i;
        if (chk_en) begin
            idle  = !(m_wait || m_owe_inv || m_owe_iss);
            e_iss = !flush_i && !m_owe_inv && m_owe_iss && !m_cross() && sb_ready;
            chk("m_lookup_rdy", lookup_rdy, idle && !flush_i);
            chk("m_sb_inv", sb_inv, flush_i || m_owe_inv);
            chk("m_sb_label_i_rdy", sb_label_i_rdy, e_iss);
            chk("m_sb_label_i", sb_label_i, m_lbl);
            chk("m_resp_vld", resp_vld, m_rv);
            chk("m_resp_hit", resp_hit, m_rh);
            if (m_rv && m_rh) chk("m_resp_data", resp_data, m_rd);
            chk("m_hit_cnt", hit_cnt, m_hits);
            chk("m_miss_cnt", miss_cnt, m_misses);
            chk("m_inv_excl", sb_inv && sb_label_i_rdy, 0);
        end
        @(posedge clk);
        model_update();
        chk_en = 1;
        @(negedge clk);
    endtask

    task automatic rand_data();
        for (int i = 0; i < 8; i++) sb_data[i*32 +: 32] = $urandom;
    endtask

    typedef struct {
        logic          en;
        logic [LW-1:0] buf_lbl;
        logic          buf_vld;
        logic [LW-1:0] look;
        logic          exp_hit;
        logic          exp_inv;
        logic          exp_iss;
        logic [LW-1:0] exp_lbl;
    } vec_t;

    vec_t tbl[6];
    logic [LINE_W-1:0] dsave;
    int inv_seen, iss_seen, resp_seen, mb;
    logic [LW-1:0] iss_lbl;
    logic [LW-1:0] pool[4];

    initial begin
        tbl[0] = '{1, LW'('h100), 1, LW'('h100), 1, 0, 1, LW'('h101)};
        tbl[1] = '{1, LW'('h300), 1, LW'('h480), 0, 1, 1, LW'('h481)};
        tbl[2] = '{1, LW'('h07F), 1, LW'('h07F), 1, 0, 0, LW'('h000)};
        tbl[3] = '{1, LW'('h7FFFFFF), 1, LW'('h7FFFFFF), 1, 0, 0, LW'('h000)};
        tbl[4] = '{0, LW'('h500), 1, LW'('h500), 0, 0, 0, LW'('h000)};
        tbl[5] = '{1, LW'('h13F), 0, LW'('h13F), 0, 1, 1, LW'('h140)};
        pool[0] = LW'('h100); pool[1] = LW'('h101); pool[2] = LW'('h07F); pool[3] = LW'('h7FFFFFF);

        rst = 1; en = 1; flush_i = 0; lookup_vld = 0; lookup_label = '0;
        sb_label_o = '0; sb_data = '0; sb_data_vld = 0; sb_ready = 1;
        @(negedge clk);
        step(); step();
        rst = 0;
        step();
        chk("rst_resp_vld", o_rv, 0);
        chk("rst_resp_data", o_rd, 0);
        chk("rst_sb_label_i", o_lbl, 0);
        chk("rst_hit_cnt", hit_cnt, 0);
        chk("rst_miss_cnt", miss_cnt, 0);
        chk("rst_lookup_rdy", o_rdy, 1);

        // immediate hit / miss / page-boundary / disabled vectors
        foreach (tbl[k]) begin
            en = tbl[k].en; sb_label_o = tbl[k].buf_lbl; sb_data_vld = tbl[k].buf_vld;
            sb_ready = 1; rand_data(); dsave = sb_data;
            lookup_vld = 1; lookup_label = tbl[k].look;
            step();
            chk("tbl_accept", o_rdy, 1);
            lookup_vld = 0;
            inv_seen = 0; iss_seen = 0; resp_seen = 0; iss_lbl = '0;
            for (int c = 0; c < 6; c++) begin
                step();
                if (c == 0) chk("tbl_resp_latency", o_rv, 1);
                if (o_rv) begin
                    resp_seen++;
                    chk("tbl_resp_hit", o_rh, tbl[k].exp_hit);
                    if (tbl[k].exp_hit) chk("tbl_resp_data", o_rd, dsave);
                end
                if (o_inv) inv_seen++;
                if (o_iss) begin iss_seen++; iss_lbl = o_lbl; end
            end
            chk("tbl_resp_count", resp_seen, 1);
            chk("tbl_inv_count", inv_seen, tbl[k].exp_inv);
            chk("tbl_issue_count", iss_seen, tbl[k].exp_iss);
            if (tbl[k].exp_iss) chk("tbl_issue_label", iss_lbl, tbl[k].exp_lbl);
            chk("tbl_back_idle", o_rdy, 1);
        end

        // in-flight prefetch: response only after the line completes
        en = 1; sb_label_o = LW'('h200); sb_data_vld = 0; sb_ready = 0;
        lookup_vld = 1; lookup_label = LW'('h200);
        step();
        lookup_vld = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("wait_no_resp", o_rv, 0);
        end
        rand_data(); dsave = sb_data; sb_data_vld = 1;
        step();
        chk("wait_vld_cycle_no_resp", o_rv, 0);
        sb_data_vld = 0; sb_ready = 1;
        step();
        chk("wait_resp_vld", o_rv, 1);
        chk("wait_resp_hit", o_rh, 1);
        chk("wait_resp_data", o_rd, dsave);
        chk("wait_issue", o_iss, 1);
        chk("wait_issue_label", o_lbl, LW'('h201));
        step();

        // flush while waiting: invalidate now, miss next cycle
        sb_label_o = LW'('h600); sb_data_vld = 0; sb_ready = 0;
        lookup_vld = 1; lookup_label = LW'('h600);
        step();
        lookup_vld = 0;
        mb = m_misses;
        flush_i = 1;
        step();
        chk("flush_inv", o_inv, 1);
        chk("flush_rdy_low", o_rdy, 0);
        chk("flush_no_resp_yet", o_rv, 0);
        flush_i = 0;
        step();
        chk("flush_resp_vld", o_rv, 1);
        chk("flush_resp_miss", o_rh, 0);
        chk("flush_miss_cnt", miss_cnt, (mb < CMAX) ? mb + 1 : CMAX);
        chk("flush_idle", o_rdy, 1);
        chk("flush_no_issue", o_iss, 0);

        // reset while waiting drops the lookup silently
        sb_label_o = LW'('h700);
        lookup_vld = 1; lookup_label = LW'('h700);
        step();
        lookup_vld = 0; rst = 1;
        step();
        rst = 0; sb_ready = 1;
        step();
        chk("rstmid_no_resp", o_rv, 0);
        chk("rstmid_rdy", o_rdy, 1);
        chk("rstmid_hit_cnt", hit_cnt, 0);
        chk("rstmid_miss_cnt", miss_cnt, 0);

        // prefetch disabled: plain misses, no buffer traffic, counter saturates
        en = 0; sb_label_o = LW'('h800); sb_data_vld = 1;
        inv_seen = 0; iss_seen = 0; resp_seen = 0;
        for (int c = 0; c < 4; c++) begin
            lookup_vld = (c < 3); lookup_label = LW'('h800 + c);
            step();
            if (o_rv) begin resp_seen++; chk("dis_resp_miss", o_rh, 0); end
            if (o_inv) inv_seen++;
            if (o_iss) iss_seen++;
        end
        lookup_vld = 0;
        step();
        if (o_rv) resp_seen++;
        chk("dis_resp_count", resp_seen, 3);
        chk("dis_no_inv", inv_seen, 0);
        chk("dis_no_issue", iss_seen, 0);
        chk("dis_miss_cnt3", miss_cnt, 3);
        lookup_vld = 1;
        for (int c = 0; c < 16; c++) step();
        lookup_vld = 0;
        step();
        chk("miss_cnt_saturated", miss_cnt, CMAX);
        chk("hit_cnt_unchanged", hit_cnt, 0);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            rst         = ($urandom_range(0, 127) == 0);
            flush_i     = ($urandom_range(0, 19) == 0);
            en          = ($urandom_range(0, 7) != 0);
            lookup_vld  = $urandom_range(0, 1);
            lookup_label = pool[$urandom_range(0, 3)];
            sb_label_o  = pool[$urandom_range(0, 3)];
            sb_data_vld = $urandom_range(0, 1);
            sb_ready    = $urandom_range(0, 1);
            rand_data();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
